exc_ctrl: RTL and testbench

Exception controller at the MEM/WB boundary. Picks the highest-priority exception on the committing instruction and sends a one-cycle exception/ERET report to cp0. It then flushes the pipeline and holds a redirect PC toward fetch until fetch accepts it. It is the initiator of the cp0 exception interface (flag, type, pc, baddr, inslot) and consumes cp0's Status/EPC/exc_intr outputs.

---
 rtl/exc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_exc_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception controller at the MEM/WB boundary: selects the winning exception of the
// committing instruction, reports it to cp0 for one cycle, then flushes and redirects fetch.
module exc_ctrl #(
    parameter logic [31:0] VEC_BEV1 = 32'hBFC00380,
    parameter logic [31:0] VEC_BEV0 = 32'h80000180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_i,
    input  logic        mem_stall_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_inslot_i,
    input  logic [7:0]  mem_exc_i,
    input  logic [31:0] mem_baddr_i,
    input  logic        exc_intr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] epc_i,
    input  logic        redirect_ready_i,
    output logic        cp0_exc_flag_o,
    output logic [4:0]  cp0_exc_type_o,
    output logic [31:0] cp0_pc_o,
    output logic [31:0] cp0_baddr_o,
    output logic        cp0_inslot_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [4:0] EXCT_INTR = 5'h00;
    localparam logic [4:0] EXCT_ADEL = 5'h04;
    localparam logic [4:0] EXCT_ADES = 5'h05;
    localparam logic [4:0] EXCT_SYS  = 5'h08;
    localparam logic [4:0] EXCT_BP   = 5'h09;
    localparam logic [4:0] EXCT_RI   = 5'h0a;
    localparam logic [4:0] EXCT_OV   = 5'h0c;
    localparam logic [4:0] EXCT_ERET = 5'h0e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REPORT = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BADDR_ZERO = 2'd0,
        BADDR_PC   = 2'd1,
        BADDR_DATA = 2'd2
    } baddr_sel_t;

    state_t      state_q;
    state_t      state_next;
    logic        commit;
    logic        take;
    logic [4:0]  sel_type;
    baddr_sel_t  sel_baddr;
    logic        sel_eret;
    logic [31:0] sel_baddr_val;
    logic [31:0] sel_rpc;

    logic        flag_q;
    logic        busy_q;
    logic [4:0]  type_q;
    logic [31:0] pc_q;
    logic [31:0] baddr_q;
    logic        inslot_q;
    logic [31:0] rpc_q;

    // Only BEV is consumed from Status; the remaining bits are intentionally ignored.
    logic unused_status;
    assign unused_status = ^{status_i[31:23], status_i[21:0]};

    assign commit = mem_valid_i && !mem_stall_i && (state_q == S_IDLE);
    assign take   = commit && (exc_intr_i || (|mem_exc_i));

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sel_type  = EXCT_INTR;
        sel_baddr = BADDR_ZERO;
        sel_eret  = 1'b0;
        if (exc_intr_i) begin
            sel_type = EXCT_INTR;
        end else if (mem_exc_i[0]) begin
            sel_type  = EXCT_ADEL;
            sel_baddr = BADDR_PC;
        end else if (mem_exc_i[1]) begin
            sel_type = EXCT_RI;
        end else if (mem_exc_i[2]) begin
            sel_type = EXCT_OV;
        end else if (mem_exc_i[3]) begin
            sel_type = EXCT_SYS;
        end else if (mem_exc_i[4]) begin
            sel_type = EXCT_BP;
        end else if (mem_exc_i[5]) begin
            sel_type = EXCT_ERET;
            sel_eret = 1'b1;
        end else if (mem_exc_i[6]) begin
            sel_type  = EXCT_ADEL;
            sel_baddr = BADDR_DATA;
        end else if (mem_exc_i[7]) begin
            sel_type  = EXCT_ADES;
            sel_baddr = BADDR_DATA;
        end
    end

    always_comb begin
        sel_baddr_val = 32'h0;
        case (sel_baddr)
            BADDR_PC:   sel_baddr_val = mem_pc_i;
            BADDR_DATA: sel_baddr_val = mem_baddr_i;
            default:    sel_baddr_val = 32'h0;
        endcase
    end

    always_comb begin
        sel_rpc = status_i[22] ? VEC_BEV1 : VEC_BEV0;
        if (sel_eret) begin
            sel_rpc = epc_i;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:   if (take) state_next = S_REPORT;
            S_REPORT: state_next = redirect_ready_i ? S_IDLE : S_WAIT;
            S_WAIT:   if (redirect_ready_i) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so nothing combinational reaches a port.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            type_q   <= 5'h0;
            pc_q     <= 32'h0;
            baddr_q  <= 32'h0;
            inslot_q <= 1'b0;
            rpc_q    <= 32'h0;
        end else begin
            state_q <= state_next;
            flag_q  <= (state_next == S_REPORT);
            busy_q  <= (state_next != S_IDLE);
            if (take) begin
                type_q   <= sel_type;
                pc_q     <= mem_pc_i;
                baddr_q  <= sel_baddr_val;
                inslot_q <= mem_inslot_i;
                rpc_q    <= sel_rpc;
            end
        end
    end

    assign cp0_exc_flag_o   = flag_q;
    assign cp0_exc_type_o   = type_q;
    assign cp0_pc_o         = pc_q;
    assign cp0_baddr_o      = baddr_q;
    assign cp0_inslot_o     = inslot_q;
    assign flush_o          = busy_q;
    assign redirect_valid_o = busy_q;
    assign redirect_pc_o    = rpc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: expected cp0 reports are queued when an event is
// driven and compared when the report flag is seen.
module tb_exc_ctrl;

    localparam logic [4:0] T_INTR = 5'h00;
    localparam logic [4:0] T_ADEL = 5'h04;
    localparam logic [4:0] T_ADES = 5'h05;
    localparam logic [4:0] T_SYS  = 5'h08;
    localparam logic [4:0] T_BP   = 5'h09;
    localparam logic [4:0] T_RI   = 5'h0a;
    localparam logic [4:0] T_OV   = 5'h0c;
    localparam logic [4:0] T_ERET = 5'h0e;

    localparam logic [7:0] F_ADEL1 = 8'h01;
    localparam logic [7:0] F_RI    = 8'h02;
    localparam logic [7:0] F_OV    = 8'h04;
    localparam logic [7:0] F_SYSC  = 8'h08;
    localparam logic [7:0] F_ERET  = 8'h20;
    localparam logic [7:0] F_ADEL2 = 8'h40;
    localparam logic [7:0] F_ADES  = 8'h80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_i, mem_stall_i, mem_inslot_i, exc_intr_i, redirect_ready_i;
    logic [31:0] mem_pc_i, mem_baddr_i, status_i, epc_i;
    logic [7:0]  mem_exc_i;
    logic        cp0_exc_flag_o, cp0_inslot_o, flush_o, redirect_valid_o;
    logic [4:0]  cp0_exc_type_o;
    logic [31:0] cp0_pc_o, cp0_baddr_o, redirect_pc_o;

    typedef struct {
        logic [4:0]  t;
        logic [31:0] pc;
        logic [31:0] baddr;
        logic        slot;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_flags = 0;

    exc_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i), .mem_pc_i(mem_pc_i),
        .mem_inslot_i(mem_inslot_i), .mem_exc_i(mem_exc_i), .mem_baddr_i(mem_baddr_i),
        .exc_intr_i(exc_intr_i), .status_i(status_i), .epc_i(epc_i),
        .redirect_ready_i(redirect_ready_i),
        .cp0_exc_flag_o(cp0_exc_flag_o), .cp0_exc_type_o(cp0_exc_type_o),
        .cp0_pc_o(cp0_pc_o), .cp0_baddr_o(cp0_baddr_o), .cp0_inslot_o(cp0_inslot_o),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic intr, input logic [7:0] exc, input logic [31:0] pc,
                                   input logic [31:0] baddr, input logic slot,
                                   input logic [31:0] status, input logic [31:0] epc);
        exp_t e;
        e.pc    = pc;
        e.slot  = slot;
        e.baddr = 32'h0;
        e.rpc   = status[22] ? 32'hBFC00380 : 32'h80000180;
        e.t     = T_INTR;
        if (intr)        e.t = T_INTR;
        else if (exc[0]) begin e.t = T_ADEL; e.baddr = pc; end
        else if (exc[1]) e.t = T_RI;
        else if (exc[2]) e.t = T_OV;
        else if (exc[3]) e.t = T_SYS;
        else if (exc[4]) e.t = T_BP;
        else if (exc[5]) begin e.t = T_ERET; e.rpc = epc; end
        else if (exc[6]) begin e.t = T_ADEL; e.baddr = baddr; end
        else if (exc[7]) begin e.t = T_ADES; e.baddr = baddr; end
        return e;
    endfunction

    // Scoreboard consumer: every flag pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (cp0_exc_flag_o) begin
            exp_t e;
            n_flags++;
            if (sb.size() == 0) begin
                check("unexpected_flag", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("type", {27'h0, cp0_exc_type_o}, {27'h0, e.t});
                check("cp0_pc", cp0_pc_o, e.pc);
                check("baddr", cp0_baddr_o, e.baddr);
                check("inslot", {31'h0, cp0_inslot_o}, {31'h0, e.slot});
                check("redirect_pc", redirect_pc_o, e.rpc);
                check("flush_with_flag", {31'h0, flush_o}, 1);
                check("valid_with_flag", {31'h0, redirect_valid_o}, 1);
            end
        end
    end

    task automatic idle_inputs();
        mem_valid_i  = 1'b0;
        mem_stall_i  = 1'b0;
        mem_exc_i    = 8'h0;
        exc_intr_i   = 1'b0;
        mem_inslot_i = 1'b0;
    endtask

    // One-cycle commit; with ready high, also waits out the report so the next call hits IDLE.
    task automatic commit_evt(input logic intr, input logic [7:0] exc, input logic [31:0] pc,
                              input logic [31:0] baddr, input logic slot);
        logic ev;
        ev = intr || (exc != 8'h0);
        @(negedge clk);
        mem_valid_i  = 1'b1;
        mem_stall_i  = 1'b0;
        exc_intr_i   = intr;
        mem_exc_i    = exc;
        mem_pc_i     = pc;
        mem_baddr_i  = baddr;
        mem_inslot_i = slot;
        if (ev) sb.push_back(model(intr, exc, pc, baddr, slot, status_i, epc_i));
        @(posedge clk);
        #1;
        idle_inputs();
        check("latency_flag", {31'h0, cp0_exc_flag_o}, {31'h0, ev});
        if (ev && redirect_ready_i) begin
            @(posedge clk);
            #1;
            check("flag_drop", {31'h0, cp0_exc_flag_o}, 0);
            check("valid_drop", {31'h0, redirect_valid_o}, 0);
        end
    endtask

    initial begin
        int valid_cycles;
        int flags0;
        rst_n = 1'b0;
        idle_inputs();
        mem_pc_i = 32'h0; mem_baddr_i = 32'h0;
        status_i = 32'h0040_0000; epc_i = 32'h0; redirect_ready_i = 1'b1;
        #3;
        check("rst_flag", {31'h0, cp0_exc_flag_o}, 0);
        check("rst_type", {27'h0, cp0_exc_type_o}, 0);
        check("rst_valid", {31'h0, redirect_valid_o}, 0);
        check("rst_flush", {31'h0, flush_o}, 0);
        check("rst_rpc", redirect_pc_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // RI, BEV=1, immediate ready
        commit_evt(1'b0, F_RI, 32'hBFC00100, 32'h0, 1'b0);

        // AdES in delay slot, BEV=0
        status_i = 32'h0;
        commit_evt(1'b0, F_ADES, 32'h80001004, 32'h80002003, 1'b1);

        // AdEL fetch vs AdEL load baddr source
        commit_evt(1'b0, F_ADEL1 | F_ADEL2, 32'h80003000, 32'h12345678, 1'b0);
        commit_evt(1'b0, F_ADEL2, 32'h80003004, 32'h87654321, 1'b0);

        // Interrupt beats Ov; Ov must never appear
        commit_evt(1'b1, F_OV, 32'h80004000, 32'h0, 1'b0);

        // Non-event commit: nothing happens
        commit_evt(1'b0, 8'h00, 32'h80005000, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("no_event_valid", {31'h0, redirect_valid_o}, 0);

        // ERET with ready low 3 cycles
        epc_i = 32'h80000400;
        redirect_ready_i = 1'b0;
        flags0 = n_flags;
        commit_evt(1'b0, F_ERET, 32'h80006000, 32'h0, 1'b0);
        epc_i = 32'hDEAD0000;
        valid_cycles = 0;
        repeat (3) begin
            @(negedge clk);
            if (redirect_valid_o) valid_cycles++;
            check("eret_rpc_stable", redirect_pc_o, 32'h80000400);
            check("eret_flush", {31'h0, flush_o}, 1);
        end
        @(negedge clk);
        redirect_ready_i = 1'b1;
        if (redirect_valid_o) valid_cycles++;
        check("eret_rpc_last", redirect_pc_o, 32'h80000400);
        @(posedge clk); #1;
        check("eret_valid_cycles", valid_cycles, 4);
        check("eret_valid_drop", {31'h0, redirect_valid_o}, 0);
        check("eret_one_flag", n_flags - flags0, 1);

        // SysC under stall for 2 cycles, then unstalled; reasserted during WAIT
        status_i = 32'h0040_0000;
        redirect_ready_i = 1'b0;
        @(negedge clk);
        mem_valid_i = 1'b1; mem_stall_i = 1'b1; mem_exc_i = F_SYSC;
        mem_pc_i = 32'h80007000; mem_inslot_i = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("stall_no_flag", {31'h0, cp0_exc_flag_o}, 0);
        end
        @(negedge clk);
        mem_stall_i = 1'b0;
        sb.push_back(model(1'b0, F_SYSC, 32'h80007000, mem_baddr_i, 1'b0, status_i, epc_i));
        @(posedge clk); #1;
        check("unstall_flag", {31'h0, cp0_exc_flag_o}, 1);
        flags0 = n_flags;
        repeat (3) @(posedge clk);
        #1;
        check("wait_held", {31'h0, redirect_valid_o}, 1);
        idle_inputs();
        @(negedge clk);
        redirect_ready_i = 1'b1;
        @(posedge clk); #1;
        check("sysc_valid_drop", {31'h0, redirect_valid_o}, 0);
        @(posedge clk); #1;
        check("wait_sysc_ignored", n_flags - flags0, 1);

        // Held event across REPORT: reported twice, back-to-back
        flags0 = n_flags;
        @(negedge clk);
        mem_valid_i = 1'b1; mem_exc_i = F_RI; mem_pc_i = 32'h80008000;
        sb.push_back(model(1'b0, F_RI, 32'h80008000, mem_baddr_i, 1'b0, status_i, epc_i));
        sb.push_back(model(1'b0, F_RI, 32'h80008000, mem_baddr_i, 1'b0, status_i, epc_i));
        repeat (3) @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("b2b_two_flags", n_flags - flags0, 2);

        // Reset during WAIT
        redirect_ready_i = 1'b0;
        commit_evt(1'b0, F_RI, 32'h80009000, 32'h0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rstw_flag", {31'h0, cp0_exc_flag_o}, 0);
        check("rstw_flush", {31'h0, flush_o}, 0);
        check("rstw_valid", {31'h0, redirect_valid_o}, 0);
        check("rstw_rpc", redirect_pc_o, 0);
        check("rstw_pc", cp0_pc_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        redirect_ready_i = 1'b1;
        commit_evt(1'b0, F_RI, 32'h8000A000, 32'h0, 1'b1);

        // Random mix of flags, interrupt, BEV and EPC
        for (int i = 0; i < 16; i++) begin
            logic [7:0] f;
            f = 8'($urandom) & 8'($urandom);
            status_i = {9'h0, 1'($urandom), 22'h0};
            epc_i = $urandom;
            commit_evt(($urandom_range(0, 5) == 0), f, $urandom, $urandom, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
